hpdl1414_scanner: RTL and testbench

Display-side reader for the 16-character display buffer. It periodically walks buffer addresses 0–15 through the buffer's read port and captures each returned byte. It converts each byte to the HPDL-1414 7-bit character set and writes it to one of four HPDL-1414 modules using the parts' parallel write protocol. It also generates the caret blink strobe that the buffer uses to flash the current write position.

---
 rtl/hpdl1414_scanner.sv | 206 ++++++++++++++++++++
 tb/tb_hpdl1414_scanner.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpdl1414_scanner.sv
// hpdl1414_scanner
//   Walks a 16-character display buffer and writes each character into
//   one of four HPDL-1414 modules through their parallel write interface.
//   A frame begins on every refresh tick that finds the scanner idle. Ticks
//   that arrive while a frame is running are dropped. The block also makes
//   the caret blink strobe for the buffer.
//
// Ports
//   i_clk          : system clock
//   i_reset        : asynchronous active-high reset
//   o_read_enable  : buffer read strobe (read data comes back one cycle later)
//   o_read_address : buffer character index 0..15
//   i_read_data    : buffer byte, valid the cycle after o_read_enable
//   o_caret_strobe : caret blink (1 = show character, 0 = show caret)
//   o_disp_data    : HPDL-1414 D6..D0, shared by all modules
//   o_disp_addr    : HPDL-1414 A1..A0 digit select, shared
//   o_disp_wr_n    : active-low WR per module, bit 0 = leftmost module
module hpdl1414_scanner #(
  parameter int SETUP_CYCLES = 1,
  parameter int WR_CYCLES    = 2,
  parameter int HOLD_CYCLES  = 1,
  parameter int REFRESH_DIV  = 12000,
  parameter int BLINK_DIV    = 3000000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  output logic       o_read_enable,
  output logic [3:0] o_read_address,
  input  logic [7:0] i_read_data,
  output logic       o_caret_strobe,
  output logic [6:0] o_disp_data,
  output logic [1:0] o_disp_addr,
  output logic [3:0] o_disp_wr_n
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int PW = 8;

  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);
  localparam logic [PW-1:0] SETUP_LAST   = PW'(SETUP_CYCLES - 1);
  localparam logic [PW-1:0] WR_LAST      = PW'(WR_CYCLES - 1);
  localparam logic [PW-1:0] HOLD_LAST    = PW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_SETUP,
    S_WRITE,
    S_HOLD,
    S_NEXT
  } state_t;

  // Printable ASCII subset of the HPDL-1414. Lower case folds to upper case.
  // Anything the part cannot show becomes a space.
  function automatic logic [6:0] map_char(input logic [7:0] b);
    logic [7:0] upper;
    logic [6:0] res;
    upper = b - 8'h20;
    res   = 7'h20;
    if (b >= 8'h20 && b <= 8'h5F) begin
      res = b[6:0];
    end else if (b >= 8'h61 && b <= 8'h7A) begin
      res = upper[6:0];
    end
    return res;
  endfunction

  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [RW-1:0] refresh_q, refresh_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          caret_q, caret_d;
  logic          read_enable_q, read_enable_d;
  logic [3:0]    read_address_q, read_address_d;
  logic [6:0]    disp_data_q, disp_data_d;
  logic [1:0]    disp_addr_q, disp_addr_d;
  logic [3:0]    disp_wr_n_q, disp_wr_n_d;
  logic          tick;

  always_comb begin
    // Free-running refresh and blink dividers.
    refresh_d = refresh_q + RW'(1);
    tick      = 1'b0;
    if (refresh_q == REFRESH_LAST) begin
      refresh_d = '0;
      tick      = 1'b1;
    end

    blink_d = blink_q + BW'(1);
    caret_d = caret_q;
    if (blink_q == BLINK_LAST) begin
      blink_d = '0;
      caret_d = ~caret_q;
    end

    state_d = state_q;
    idx_d   = idx_q;
    phase_d = phase_q;

    case (state_q)
      S_IDLE: begin
        if (tick) begin
          idx_d   = 4'd0;
          state_d = S_READ;
        end
      end
      S_READ:  state_d = S_LATCH;
      S_LATCH: begin
        phase_d = '0;
        state_d = S_SETUP;
      end
      S_SETUP: begin
        if (phase_q == SETUP_LAST) begin
          phase_d = '0;
          state_d = S_WRITE;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      S_WRITE: begin
        if (phase_q == WR_LAST) begin
          phase_d = '0;
          state_d = S_HOLD;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      S_HOLD: begin
        if (phase_q == HOLD_LAST) begin
          phase_d = '0;
          state_d = S_NEXT;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      S_NEXT: begin
        if (idx_q == 4'd15) begin
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state, so each output flop
    // lines up with the state it belongs to.
    read_enable_d  = (state_d == S_READ);
    read_address_d = idx_d;

    // Buffer data arrives during LATCH. Capture it on the LATCH edge so that
    // data and digit address are stable for the whole SETUP window.
    disp_data_d = disp_data_q;
    disp_addr_d = disp_addr_q;
    if (state_q == S_LATCH) begin
      disp_data_d = map_char(i_read_data);
      disp_addr_d = 2'd3 - idx_q[1:0];  // HPDL digit 0 is the rightmost
    end

    disp_wr_n_d = 4'hF;
    if (state_d == S_WRITE) begin
      disp_wr_n_d[idx_d[3:2]] = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      phase_q        <= '0;
      refresh_q      <= '0;
      blink_q        <= '0;
      caret_q        <= 1'b1;
      read_enable_q  <= 1'b0;
      read_address_q <= '0;
      disp_data_q    <= '0;
      disp_addr_q    <= '0;
      disp_wr_n_q    <= 4'hF;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      phase_q        <= phase_d;
      refresh_q      <= refresh_d;
      blink_q        <= blink_d;
      caret_q        <= caret_d;
      read_enable_q  <= read_enable_d;
      read_address_q <= read_address_d;
      disp_data_q    <= disp_data_d;
      disp_addr_q    <= disp_addr_d;
      disp_wr_n_q    <= disp_wr_n_d;
    end
  end

  assign o_read_enable  = read_enable_q;
  assign o_read_address = read_address_q;
  assign o_caret_strobe = caret_q;
  assign o_disp_data    = disp_data_q;
  assign o_disp_addr    = disp_addr_q;
  assign o_disp_wr_n    = disp_wr_n_q;

endmodule

// File: tb/tb_hpdl1414_scanner.sv
// Testbench for hpdl1414_scanner. Three instances run side by side:
//   u_a : default write timing, REFRESH_DIV=250, BLINK_DIV=5
//   u_b : SETUP=2, WR=3, HOLD=2, REFRESH_DIV=360
//   u_c : default timing, REFRESH_DIV=100 (frame longer than the tick period)
// The pins are traced for a fixed window and then compared with a pulse list
// built from the frame/tick rules.
module tb_hpdl1414_scanner;

  localparam int WIN = 900;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       re [3];
  logic [3:0] ra [3];
  logic [7:0] rd [3];
  logic       cs [3];
  logic [6:0] dd [3];
  logic [1:0] da [3];
  logic [3:0] wr [3];

  hpdl1414_scanner #(.SETUP_CYCLES(1), .WR_CYCLES(2), .HOLD_CYCLES(1),
                     .REFRESH_DIV(250), .BLINK_DIV(5)) u_a (
    .i_clk(clk), .i_reset(rst), .o_read_enable(re[0]), .o_read_address(ra[0]),
    .i_read_data(rd[0]), .o_caret_strobe(cs[0]), .o_disp_data(dd[0]),
    .o_disp_addr(da[0]), .o_disp_wr_n(wr[0]));

  hpdl1414_scanner #(.SETUP_CYCLES(2), .WR_CYCLES(3), .HOLD_CYCLES(2),
                     .REFRESH_DIV(360)) u_b (
    .i_clk(clk), .i_reset(rst), .o_read_enable(re[1]), .o_read_address(ra[1]),
    .i_read_data(rd[1]), .o_caret_strobe(cs[1]), .o_disp_data(dd[1]),
    .o_disp_addr(da[1]), .o_disp_wr_n(wr[1]));

  hpdl1414_scanner #(.REFRESH_DIV(100)) u_c (
    .i_clk(clk), .i_reset(rst), .o_read_enable(re[2]), .o_read_address(ra[2]),
    .i_read_data(rd[2]), .o_caret_strobe(cs[2]), .o_disp_data(dd[2]),
    .o_disp_addr(da[2]), .o_disp_wr_n(wr[2]));

  function automatic int p_set(input int i);  return (i == 1) ? 2 : 1; endfunction
  function automatic int p_wr(input int i);   return (i == 1) ? 3 : 2; endfunction
  function automatic int p_hold(input int i); return (i == 1) ? 2 : 1; endfunction
  function automatic int p_div(input int i);
    return (i == 0) ? 250 : ((i == 1) ? 360 : 100);
  endfunction

  // Buffer model: one byte array per frame, 1-cycle read latency.
  logic [7:0] bufm [3][5][16];
  int         fc [3] = '{0, 0, 0};

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (re[i]) begin
        rd[i] <= bufm[i][fc[i]][ra[i]];
        if (ra[i] == 4'd15 && fc[i] < 4) fc[i] <= fc[i] + 1;
      end
    end
  end

  // Character set rule in plain integer ranges.
  function automatic int map_ref(input int b);
    if (b >= 32 && b <= 95) return b;
    if (b >= 97 && b <= 122) return b - 32;
    return 32;
  endfunction

  typedef struct {
    logic [7:0] in_b;
    logic [6:0] exp;
  } map_vec_t;
  map_vec_t mv [16];

  logic [3:0] tr_wr [3][WIN];
  logic [1:0] tr_da [3][WIN];
  logic [6:0] tr_dd [3][WIN];
  logic       tr_re [3][WIN];
  logic [3:0] tr_ra [3][WIN];
  logic       tr_cs [WIN];

  int ap_start [3][80];
  int ap_len   [3][80];
  int ap_wr    [3][80];
  int ap_addr  [3][80];
  int ap_data  [3][80];
  int ap_ok    [3][80];
  int n_act    [3];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int ap_get_start(input int i, input int p);
    return (p < n_act[i] && p < 80) ? ap_start[i][p] : -1;
  endfunction

  task automatic analyze(input int i);
    int cpc, viol, len, ok, nf, busy, p, es, r, rok, ew, edat;
    int fs [8];
    cpc = 3 + p_set(i) + p_wr(i) + p_hold(i);
    viol = 0;
    n_act[i] = 0;
    for (int k = 0; k < WIN; k++) begin
      if ($countones(~tr_wr[i][k]) > 1) viol++;
      if (tr_wr[i][k] != 4'hF && (k == 0 || tr_wr[i][(k > 0) ? k - 1 : 0] == 4'hF)) begin
        len = 0;
        ok  = 1;
        while (k + len < WIN && tr_wr[i][k + len] != 4'hF) begin
          if (tr_wr[i][k + len] != tr_wr[i][k]) ok = 0;
          len++;
        end
        for (int j = k - p_set(i); j < k + len + p_hold(i); j++) begin
          if (j >= 0 && j < WIN) begin
            if (tr_da[i][j] != tr_da[i][k] || tr_dd[i][j] != tr_dd[i][k]) ok = 0;
            if ((j < k || j >= k + len) && tr_wr[i][j] != 4'hF) ok = 0;
          end
        end
        if (n_act[i] < 80) begin
          ap_start[i][n_act[i]] = k;
          ap_len[i][n_act[i]]   = len;
          ap_wr[i][n_act[i]]    = int'(tr_wr[i][k]);
          ap_addr[i][n_act[i]]  = int'(tr_da[i][k]);
          ap_data[i][n_act[i]]  = int'(tr_dd[i][k]);
          ap_ok[i][n_act[i]]    = ok;
        end
        n_act[i]++;
      end
    end
    chk($sformatf("inst%0d_wr_onehot_violations", i), viol, 0);

    // Frames start on ticks that find the scanner idle.
    nf = 0;
    busy = 0;
    for (int t = p_div(i); t + 16 * cpc <= WIN && nf < 8; t += p_div(i)) begin
      if (t - 1 >= busy) begin
        fs[nf] = t;
        nf++;
        busy = t + 16 * cpc;
      end
    end
    chk($sformatf("inst%0d_pulse_count", i), n_act[i], 16 * nf);

    for (int f = 0; f < nf; f++) begin
      for (int idx = 0; idx < 16; idx++) begin
        p = f * 16 + idx;
        if (p < n_act[i] && p < 80) begin
          es = fs[f] + idx * cpc + 2 + p_set(i);
          ew = 15 & ~(1 << (idx / 4));
          edat = (i == 0 && f == 1) ? int'(mv[idx].exp) : map_ref(int'(bufm[i][f][idx]));
          r = fs[f] + idx * cpc;
          rok = (tr_re[i][r] == 1'b1 && int'(tr_ra[i][r]) == idx &&
                 tr_re[i][r + 1] == 1'b0 && tr_re[i][r - 1] == 1'b0) ? 1 : 0;
          chk($sformatf("inst%0d_f%0d_i%0d_start", i, f, idx), ap_start[i][p], es);
          chk($sformatf("inst%0d_f%0d_i%0d_wr_len", i, f, idx), ap_len[i][p], p_wr(i));
          chk($sformatf("inst%0d_f%0d_i%0d_wr_n", i, f, idx), ap_wr[i][p], ew);
          chk($sformatf("inst%0d_f%0d_i%0d_addr", i, f, idx), ap_addr[i][p], 3 - (idx % 4));
          chk($sformatf("inst%0d_f%0d_i%0d_data", i, f, idx), ap_data[i][p], edat);
          chk($sformatf("inst%0d_f%0d_i%0d_stable", i, f, idx), ap_ok[i][p], 1);
          chk($sformatf("inst%0d_f%0d_i%0d_read", i, f, idx), rok, 1);
        end
      end
    end
  endtask

  initial begin
    string s;
    int    guard, early, first_re, bad_cs, t15;
    logic  exp_cs [11];
    s = "TINY_TAPEOUT_10!";
    exp_cs = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    mv = '{'{8'h61, 7'h41}, '{8'h7A, 7'h5A}, '{8'h07, 7'h20}, '{8'h60, 7'h20},
           '{8'hFF, 7'h20}, '{8'h5F, 7'h5F}, '{8'h20, 7'h20}, '{8'h1F, 7'h20},
           '{8'h7B, 7'h20}, '{8'h80, 7'h20}, '{8'h41, 7'h41}, '{8'h6D, 7'h4D},
           '{8'h30, 7'h30}, '{8'h7F, 7'h20}, '{8'h21, 7'h21}, '{8'h5A, 7'h5A}};
    for (int i = 0; i < 3; i++) begin
      for (int a = 0; a < 16; a++) begin
        bufm[i][0][a] = s[a];
        for (int f = 1; f < 5; f++) bufm[i][f][a] = 8'($urandom_range(0, 255));
      end
    end
    for (int a = 0; a < 16; a++) bufm[0][1][a] = mv[a].in_b;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("inst%0d_reset_wr_n", i), int'(wr[i]), 15);
      chk($sformatf("inst%0d_reset_read_enable", i), int'(re[i]), 0);
      chk($sformatf("inst%0d_reset_read_address", i), int'(ra[i]), 0);
      chk($sformatf("inst%0d_reset_disp_data", i), int'(dd[i]), 0);
      chk($sformatf("inst%0d_reset_disp_addr", i), int'(da[i]), 0);
      chk($sformatf("inst%0d_reset_caret", i), int'(cs[i]), 1);
    end

    rst = 1'b0;
    for (int k = 0; k < WIN; k++) begin
      for (int i = 0; i < 3; i++) begin
        tr_wr[i][k] = wr[i];
        tr_da[i][k] = da[i];
        tr_dd[i][k] = dd[i];
        tr_re[i][k] = re[i];
        tr_ra[i][k] = ra[i];
      end
      tr_cs[k] = cs[0];
      @(negedge clk);
    end

    for (int i = 0; i < 3; i++) analyze(i);

    // Hand-written corner checks.
    chk("a_pulse0_start", ap_get_start(0, 0), 253);
    if (n_act[0] > 15) begin
      chk("a_pulse0_wr_n", ap_wr[0][0], 4'b1110);
      chk("a_pulse0_addr", ap_addr[0][0], 3);
      chk("a_pulse0_data", ap_data[0][0], 8'h54);
      chk("a_pulse15_wr_n", ap_wr[0][15], 4'b0111);
      chk("a_pulse15_addr", ap_addr[0][15], 0);
      chk("a_pulse15_data", ap_data[0][15], 8'h21);
    end else begin
      chk("a_pulse_count_for_hand_checks", n_act[0], 16);
    end

    first_re = -1;
    for (int k = 0; k < WIN; k++) if (first_re < 0 && tr_re[1][k]) first_re = k;
    chk("b_first_read", first_re, 360);
    t15 = ap_get_start(1, 15);
    if (t15 >= 0) begin
      chk("b_frame_length", t15 + ap_len[1][15] + 2 + 1 - first_re, 160);
      chk("b_wr_low_cycles", ap_len[1][15], 3);
    end else begin
      chk("b_pulse15_present", t15, 514);
    end

    chk("c_first_frame_start", ap_get_start(2, 0), 103);
    chk("c_second_frame_offset", ap_get_start(2, 16) - ap_get_start(2, 0), 200);

    for (int k = 0; k < 11; k++) chk($sformatf("a_caret_k%0d", k), int'(tr_cs[k]), int'(exp_cs[k]));
    bad_cs = 0;
    for (int k = 0; k < WIN; k++) if (int'(tr_cs[k]) != (((k / 5) % 2 == 0) ? 1 : 0)) bad_cs++;
    chk("a_caret_trace_errors", bad_cs, 0);

    // Reset in the middle of a WR pulse.
    guard = 0;
    while (wr[0] == 4'hF && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    chk("a_reached_write", (wr[0] != 4'hF) ? 1 : 0, 1);
    #1 rst = 1'b1;
    #1;
    chk("a_async_reset_wr_n", int'(wr[0]), 15);
    chk("a_async_reset_caret", int'(cs[0]), 1);
    chk("a_async_reset_read_enable", int'(re[0]), 0);
    chk("a_async_reset_disp_data", int'(dd[0]), 0);
    chk("a_async_reset_disp_addr", int'(da[0]), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    early = 0;
    for (int k = 0; k < p_div(0) + 3; k++) begin
      if (wr[0] != 4'hF) early++;
      @(negedge clk);
    end
    chk("a_no_wr_before_tick", early, 0);
    chk("a_first_wr_after_reset", int'(wr[0]), 4'b1110);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
